// File: rtl/uart_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_frame_rx
// Description : Oversampling UART receiver for 12-bit frames
//               (start, even parity, d0..d7, two stops) with valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] c_DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0] c_SUB_SAMPLE = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] c_SUB_LAST   = SUB_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_prev;
  logic [DIV_W-1:0] r_div;
  logic [SUB_W-1:0] r_sub;
  logic [3:0]       r_idx;
  logic             r_par;
  logic [7:0]       r_shreg;
  logic             r_stop_idx;
  logic             r_stop_bad;

  logic w_tick;
  logic w_sample;
  logic w_wrap;
  logic w_fall;
  logic w_accept;

  assign w_tick   = (r_state != S_IDLE) && (r_div == c_DIV_LAST);
  assign w_sample = w_tick && (r_sub == c_SUB_SAMPLE);
  assign w_wrap   = w_tick && (r_sub == c_SUB_LAST);
  assign w_fall   = r_rx_prev & ~r_rx_s;
  assign w_accept = rx_valid & rx_ready;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_div      <= '0;
      r_sub      <= '0;
      r_idx      <= 4'd0;
      r_par      <= 1'b0;
      r_shreg    <= 8'h00;
      r_stop_idx <= 1'b0;
      r_stop_bad <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;

      if (r_state == S_IDLE) begin
        r_div <= '0;
        r_sub <= '0;
      end else begin
        r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
        if (w_tick) r_sub <= r_sub + 1'b1;
      end

      if (w_accept && (r_state != S_DONE)) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          // Line back high at mid-start is a glitch; otherwise wait for bit end.
          if (w_sample && r_rx_s) begin
            r_state <= S_IDLE;
          end else if (w_wrap) begin
            r_state <= S_DATA;
            r_idx   <= 4'd0;
          end
        end
        S_DATA: begin
          if (w_sample) begin
            if (r_idx == 4'd0) r_par <= r_rx_s;
            else               r_shreg <= {r_rx_s, r_shreg[7:1]};
            if (r_idx == 4'd8) begin
              r_state    <= S_STOP;
              r_stop_idx <= 1'b0;
              r_stop_bad <= 1'b0;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (w_sample) begin
            if (!r_rx_s) r_stop_bad <= 1'b1;
            r_stop_idx <= 1'b1;
            if (r_stop_idx) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!rx_valid || rx_ready) begin
            rx_data    <= r_shreg;
            parity_err <= (r_par != ^r_shreg);
            frame_err  <= r_stop_bad;
            rx_valid   <= 1'b1;
            overrun    <= 1'b0;
          end else begin
            overrun <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
